// File: rtl/touch_packet_rx.sv
// touch_packet_rx: 8N1 UART receiver plus 5-byte touch report parser with a
// valid/ready output register and a sticky overrun flag.
// Optional feature: define TOUCH_SCALE_EN to scale X/Y to SCREEN_W x SCREEN_H
// (adds one pipeline register between parser and output register).
module touch_packet_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned SCREEN_W     = 800,
  parameter int unsigned SCREEN_H     = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  output logic        touch_valid,
  input  logic        touch_ready,
  output logic [11:0] touch_x,
  output logic [11:0] touch_y,
  output logic        touch_pen,
  output logic        frame_err,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam int unsigned COORD_W = 12;
  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    P_HUNT,
    P_B1,
    P_B2,
    P_B3,
    P_B4
  } p_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_s;

  // Two-flop synchronizer, idle-high reset value
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rxd};
  end

  assign rx_s = sync_q[1];

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             armed_q, armed_d;
  logic             byte_stb_c;
  logic             stop_err_c;

  // Receiver state register
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      armed_q    <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      armed_q    <= armed_d;
    end
  end

  // Receiver next-state: mid-bit sampling; after a bad stop bit, stay idle
  // until the line has been seen high again (armed)
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    armed_d    = armed_q;
    byte_stb_c = 1'b0;
    stop_err_c = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          if (rx_s) begin
            byte_stb_c = 1'b1;
          end else begin
            stop_err_c = 1'b1;
            armed_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packet parser
  // ---------------------------------------------------------------------------
  p_state_t          p_state_q, p_state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [6:0]        y_lo_q, y_lo_d;
  logic              pen_q, pen_d;
  logic              pub_c;
  logic [COORD_W-1:0] pub_x, pub_y;
  logic              pub_pen;

  // Parser state register
  always_ff @(posedge clk) begin
    if (reset) begin
      p_state_q <= P_HUNT;
      x_q       <= '0;
      y_lo_q    <= '0;
      pen_q     <= 1'b0;
    end else begin
      p_state_q <= p_state_d;
      x_q       <= x_d;
      y_lo_q    <= y_lo_d;
      pen_q     <= pen_d;
    end
  end

  // Parser next-state: headers resync from any state, framing errors drop to HUNT
  always_comb begin
    p_state_d = p_state_q;
    x_d       = x_q;
    y_lo_d    = y_lo_q;
    pen_d     = pen_q;
    pub_c     = 1'b0;
    if (stop_err_c) begin
      p_state_d = P_HUNT;
    end else if (byte_stb_c) begin
      if (shreg_q[7]) begin
        if (shreg_q[6:1] == 6'd0) begin
          pen_d     = shreg_q[0];
          p_state_d = P_B1;
        end else begin
          p_state_d = P_HUNT;
        end
      end else begin
        case (p_state_q)
          P_B1: begin
            x_d[6:0]  = shreg_q[6:0];
            p_state_d = P_B2;
          end
          P_B2: begin
            x_d[11:7] = shreg_q[4:0];
            p_state_d = P_B3;
          end
          P_B3: begin
            y_lo_d    = shreg_q[6:0];
            p_state_d = P_B4;
          end
          P_B4: begin
            pub_c     = 1'b1;
            p_state_d = P_HUNT;
          end
          default: p_state_d = P_HUNT;
        endcase
      end
    end
  end

  assign pub_x   = x_q;
  assign pub_y   = {shreg_q[4:0], y_lo_q};
  assign pub_pen = pen_q;

  // ---------------------------------------------------------------------------
  // Optional scaling stage
  // ---------------------------------------------------------------------------
  logic               load_c;
  logic [COORD_W-1:0] load_x, load_y;
  logic               load_pen;

`ifdef TOUCH_SCALE_EN
  localparam int unsigned SW_W = $clog2(SCREEN_W + 1);
  localparam int unsigned SH_W = $clog2(SCREEN_H + 1);
  localparam int unsigned PX_W = COORD_W + SW_W;
  localparam int unsigned PY_W = COORD_W + SH_W;

  logic               stg_valid_q;
  logic [COORD_W-1:0] stg_x_q, stg_y_q;
  logic               stg_pen_q;
  logic [PX_W-1:0]    prod_x;
  logic [PY_W-1:0]    prod_y;

  // Pipeline register between parser and scaler
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid_q <= 1'b0;
      stg_x_q     <= '0;
      stg_y_q     <= '0;
      stg_pen_q   <= 1'b0;
    end else begin
      stg_valid_q <= pub_c;
      if (pub_c) begin
        stg_x_q   <= pub_x;
        stg_y_q   <= pub_y;
        stg_pen_q <= pub_pen;
      end
    end
  end

  // Truncating scale: (coord * screen) >> 12
  assign prod_x   = PX_W'(stg_x_q) * PX_W'(SCREEN_W);
  assign prod_y   = PY_W'(stg_y_q) * PY_W'(SCREEN_H);
  assign load_c   = stg_valid_q;
  assign load_x   = COORD_W'(prod_x >> COORD_W);
  assign load_y   = COORD_W'(prod_y >> COORD_W);
  assign load_pen = stg_pen_q;
`else
  assign load_c   = pub_c;
  assign load_x   = pub_x;
  assign load_y   = pub_y;
  assign load_pen = pub_pen;
`endif

  // ---------------------------------------------------------------------------
  // Output register, handshake and status flags
  // ---------------------------------------------------------------------------

  // Single-entry report register; a new report overwrites a pending one
  always_ff @(posedge clk) begin
    if (reset) begin
      touch_valid <= 1'b0;
      touch_x     <= '0;
      touch_y     <= '0;
      touch_pen   <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_err <= stop_err_c;
      if (load_c) begin
        touch_valid <= 1'b1;
        touch_x     <= load_x;
        touch_y     <= load_y;
        touch_pen   <= load_pen;
      end else if (touch_valid && touch_ready) begin
        touch_valid <= 1'b0;
      end
      if (load_c && touch_valid && !touch_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_touch_packet_rx.sv
// Directed bench for touch_packet_rx: table-driven packets plus hand-written
// resync, framing-error, overrun, glitch and reset sequences.
module tb_touch_packet_rx;

  localparam int CPB = 16;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxd;
  logic        touch_valid;
  logic        touch_ready;
  logic [11:0] touch_x;
  logic [11:0] touch_y;
  logic        touch_pen;
  logic        frame_err;
  logic        overrun;
  logic        overrun_clr;

  touch_packet_rx #(
    .CLKS_PER_BIT(CPB),
    .SCREEN_W(800),
    .SCREEN_H(480)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .touch_valid(touch_valid),
    .touch_ready(touch_ready),
    .touch_x(touch_x),
    .touch_y(touch_y),
    .touch_pen(touch_pen),
    .frame_err(frame_err),
    .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] bytes;
    logic [11:0] x;
    logic [11:0] y;
    logic        pen;
  } vec_t;

  vec_t vecs [4];

  int n_tests = 0;
  int n_fail  = 0;
  int rep_cnt = 0;
  int vhigh   = 0;
  int fe_cnt  = 0;
  logic [11:0] cap_x = '0;
  logic [11:0] cap_y = '0;
  logic        cap_pen = 1'b0;

  // Monitor: accepted reports, valid-high cycles, frame_err-high cycles
  always @(negedge clk) begin
    if (touch_valid) vhigh++;
    if (touch_valid && touch_ready) begin
      rep_cnt++;
      cap_x   = touch_x;
      cap_y   = touch_y;
      cap_pen = touch_pen;
    end
    if (frame_err) fe_cnt++;
  end

  function automatic int exp_x(input int v);
`ifdef TOUCH_SCALE_EN
    return (v * 800) / 4096;
`else
    return v;
`endif
  endfunction

  function automatic int exp_y(input int v);
`ifdef TOUCH_SCALE_EN
    return (v * 480) / 4096;
`else
    return v;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_bit;
    tick(CPB);
    rxd = 1'b1;
    tick(GAP);
  endtask

  task automatic send_packet(input logic [39:0] p);
    for (int i = 0; i < 5; i++) begin
      send_byte(p[39-8*i -: 8], 1'b1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(touch_valid), 0);
    check({tag, "_x"}, int'(touch_x), 0);
    check({tag, "_y"}, int'(touch_y), 0);
    check({tag, "_pen"}, int'(touch_pen), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  int r0, v0, f0;

  initial begin
    vecs[0] = '{bytes: 40'h81_00_10_7F_1F, x: 12'd2048, y: 12'd4095, pen: 1'b1};
    vecs[1] = '{bytes: 40'h80_05_00_03_00, x: 12'd5,    y: 12'd3,    pen: 1'b0};
    vecs[2] = '{bytes: 40'h81_7F_7F_55_6A, x: 12'd4095, y: 12'd1365, pen: 1'b1};
    vecs[3] = '{bytes: 40'h80_2A_15_00_00, x: 12'd2730, y: 12'd0,    pen: 1'b0};

    reset       = 1'b1;
    rxd         = 1'b1;
    touch_ready = 1'b1;
    overrun_clr = 1'b0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(4);

    // Table-driven packets, consumer always ready
    for (int i = 0; i < 4; i++) begin
      r0 = rep_cnt;
      v0 = vhigh;
      send_packet(vecs[i].bytes);
      tick(4);
      check($sformatf("vec%0d_reports", i), rep_cnt - r0, 1);
      check($sformatf("vec%0d_valid_cycles", i), vhigh - v0, 1);
      check($sformatf("vec%0d_x", i), int'(cap_x), exp_x(int'(vecs[i].x)));
      check($sformatf("vec%0d_y", i), int'(cap_y), exp_y(int'(vecs[i].y)));
      check($sformatf("vec%0d_pen", i), int'(cap_pen), int'(vecs[i].pen));
    end

    // Resync: second header restarts the packet
    r0 = rep_cnt;
    send_byte(8'h80, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h81, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(4);
    check("resync_reports", rep_cnt - r0, 1);
    check("resync_x", int'(cap_x), exp_x(1));
    check("resync_y", int'(cap_y), exp_y(2));
    check("resync_pen", int'(cap_pen), 1);

    // Framing error on the third byte kills the packet
    r0 = rep_cnt;
    f0 = fe_cnt;
    send_byte(8'h81, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(4);
    check("ferr_pulse_cycles", fe_cnt - f0, 1);
    check("ferr_reports", rep_cnt - r0, 0);
    r0 = rep_cnt;
    send_packet(40'h80_0A_00_0B_00);
    tick(4);
    check("ferr_next_reports", rep_cnt - r0, 1);
    check("ferr_next_x", int'(cap_x), exp_x(10));
    check("ferr_next_y", int'(cap_y), exp_y(11));
    check("ferr_next_pen", int'(cap_pen), 0);

    // Overrun: two reports without acceptance
    touch_ready = 1'b0;
    r0 = rep_cnt;
    send_packet(40'h80_0A_00_00_00);
    tick(4);
    check("ovr_first_valid", int'(touch_valid), 1);
    check("ovr_first_x", int'(touch_x), exp_x(10));
    check("ovr_first_flag", int'(overrun), 0);
    send_packet(40'h80_14_00_00_00);
    tick(4);
    check("ovr_second_valid", int'(touch_valid), 1);
    check("ovr_second_x", int'(touch_x), exp_x(20));
    check("ovr_second_flag", int'(overrun), 1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    tick(1);
    check("ovr_cleared", int'(overrun), 0);
    check("ovr_still_valid", int'(touch_valid), 1);
    touch_ready = 1'b1;
    tick(1);
    check("ovr_accepted_valid", int'(touch_valid), 0);
    check("ovr_accept_count", rep_cnt - r0, 1);

    // Glitch: short low pulse is not a start bit
    r0 = rep_cnt;
    f0 = fe_cnt;
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(40);
    check("glitch_frame_err", fe_cnt - f0, 0);
    check("glitch_reports", rep_cnt - r0, 0);

    // Reset mid-packet with a pending report and overrun set
    touch_ready = 1'b0;
    send_packet(40'h80_01_00_01_00);
    send_packet(40'h81_7F_1F_7F_1F);
    tick(4);
    check("prerst_valid", int'(touch_valid), 1);
    check("prerst_overrun", int'(overrun), 1);
    check("prerst_x", int'(touch_x), exp_x(4095));
    send_byte(8'h81, 1'b1);
    send_byte(8'h07, 1'b1);
    rxd = 1'b0;
    tick(3 * CPB);
    reset = 1'b1;
    rxd   = 1'b1;
    tick(1);
    check_all_zero("midrst");
    tick(2);
    reset = 1'b0;
    touch_ready = 1'b1;
    tick(4);
    r0 = rep_cnt;
    send_packet(40'h80_03_00_04_00);
    tick(4);
    check("postrst_reports", rep_cnt - r0, 1);
    check("postrst_x", int'(cap_x), exp_x(3));
    check("postrst_y", int'(cap_y), exp_y(4));
    check("postrst_pen", int'(cap_pen), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/touch_packet_rx.md
# touch_packet_rx

Serial front end for the resistive touchscreen controller on the GPIO_1 touchscreen UART line. It samples the 8N1 byte stream itself and parses 5-byte touch reports into 12-bit X/Y coordinates plus pen state. Results are presented on a valid/ready interface to the downstream system fabric, i.e. the touch-input slave behind the HPS/Nios bus. It replaces a generic UART core plus software packet parsing.

## Interface
Parameters:
- CLKS_PER_BIT, 5208: clock cycles per UART bit (50 MHz / 9600 baud). Minimum 4.
- SCREEN_W, 800: horizontal scaling target, used only with scaling compiled in.
- SCREEN_H, 480: vertical scaling target, used only with scaling compiled in.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- rxd  in  1  asynchronous UART line from the touchscreen (idle high).
- touch_valid  out  1  a coordinate report is pending.
- touch_ready  in  1  consumer accepts the report in the cycle where touch_valid && touch_ready.
- touch_x  out  12  X coordinate.
- touch_y  out  12  Y coordinate.
- touch_pen  out  1  1 = pen down, 0 = pen up.
- frame_err  out  1  one-cycle pulse on a stop-bit error.
- overrun  out  1  sticky flag: an unaccepted report was overwritten.
- overrun_clr  in  1  clears overrun; a new overrun event in the same cycle wins.

## Operation
- **Synchronizer:** rxd passes through 2 flops (reset value 1) before any use.
- **Receiver FSM: IDLE -> START -> DATA -> STOP -> IDLE.**
  - IDLE: a synchronized low enters START with the bit counter cleared.
  - START: at CLKS_PER_BIT/2 cycles the line is re-sampled. High means a glitch; return to IDLE with nothing emitted.
  - DATA: 8 bits are sampled LSB first, one every CLKS_PER_BIT cycles.
  - STOP: the line is sampled once. High produces an internal byte strobe. Low pulses frame_err, discards the byte, forces the parser to HUNT, and the FSM waits in IDLE for the line to return high.
- **Parser states: HUNT, B1, B2, B3, B4.**
  - A header byte has bit7=1 and bits6:1=0; the pen state is taken from bit0. A header is accepted in any state (resync) and moves the parser to B1.
  - Any other byte with bit7=1 sends the parser to HUNT.
  - A byte with bit7=0 in HUNT is dropped.
  - Data bytes in order:
    - B1 -> X[6:0] from bits 6:0
    - B2 -> X[11:7] from bits 4:0
    - B3 -> Y[6:0]
    - B4 -> Y[11:7]
  - Completing B4 publishes the report and returns to HUNT. Bits 6:5 of the high bytes are ignored.
- **Output register:** a published report loads touch_x/y/pen and sets touch_valid.
  - touch_valid clears on acceptance.
  - If a new report publishes while a report is pending and is not accepted in that cycle, the new report overwrites the old one, touch_valid stays 1, and overrun sets.
  - If publish and acceptance happen in the same cycle, the old report is consumed, the new one loads, and there is no overrun.
- **Reset values:** touch_valid=0, touch_x=0, touch_y=0, touch_pen=0, frame_err=0, overrun=0, receiver in IDLE, parser in HUNT. Reset mid-byte or mid-packet discards all partial state.

## Timing
- Byte strobe occurs in the cycle of the stop-bit sample, cycle N.
- Unscaled build: the parser updates at N+1, and touch_valid/touch_x/touch_y are visible from N+1.
- Scaled build: an extra register stage applies, and outputs are visible from N+2.
- frame_err is high for exactly cycle N+1.
- touch_x/y/pen hold steady while touch_valid=1 unless overwritten by an overrun.
- Minimum report spacing is 50×CLKS_PER_BIT cycles, so a single-entry output register suffices.

## Configuration
- TOUCH_SCALE_EN defined:
  - touch_x = (X × SCREEN_W) >> 12 and touch_y = (Y × SCREEN_H) >> 12.
  - The products are computed unsigned at 12+clog2(max) bits and truncated, never rounded.
  - One pipeline register is added.
  - Output range is 0..SCREEN_W−1 and 0..SCREEN_H−1, zero-extended to 12 bits.
- TOUCH_SCALE_EN undefined: raw 12-bit controller coordinates (0..4095) with no extra latency.

## Test plan
Bench parameter: CLKS_PER_BIT=16.
- **Basic report:** bytes 0x81,0x00,0x10,0x7F,0x1F with touch_ready=1 -> touch_valid for 1 cycle, x=2048, y=4095, pen=1. With TOUCH_SCALE_EN: x=400, y=479.
- **Resync:** bytes 0x80,0x05,0x81,0x01,0x00,0x02,0x00 -> exactly one report: x=1, y=2, pen=1.
- **Framing error:** stop bit driven low on the 3rd byte of a packet -> frame_err pulses, no report. The next clean packet reports correctly.
- **Overrun:** hold touch_ready=0 and send two packets (x=10, then x=20) -> touch_valid stays 1, x=20, overrun=1. Then pulse overrun_clr -> overrun=0.
- **Glitch:** a 3-cycle low pulse on rxd -> no byte, no frame_err. Then assert reset mid-packet, followed by a full packet -> only the post-reset packet reports, and all outputs read 0 during reset.
